// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline.
// Runs the data-memory access over a req/ack bus, stalls upstream while the
// access is outstanding, and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_regwrite,
  input  logic        mem_memwrite,
  input  logic        mem_lw,
  input  logic [1:0]  mem_datatoreg,
  input  logic [4:0]  mem_rdes,
  input  logic [31:0] mem_aluout,
  input  logic [31:0] mem_rdatab,
  input  logic [31:0] mem_pcfour,
  input  logic [31:0] mem_luidata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rdes,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        supp_q, supp_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rdes_q, wb_rdes_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;
  logic        bus_err_q, bus_err_d;

  logic access;
  logic misaligned;

  assign access     = mem_lw | mem_memwrite;
  assign misaligned = access & (mem_aluout[1:0] != 2'b00);

  // Writeback mux; 'ld' is the load value available for select 01
  function automatic logic [31:0] sel_wb(input logic [1:0] sel, input logic [31:0] ld,
                                         input logic [31:0] alu, input logic [31:0] pc4,
                                         input logic [31:0] lui);
    logic [31:0] r;
    case (sel)
      2'b00:   r = alu;
      2'b01:   r = ld;
      2'b10:   r = pc4;
      default: r = lui;
    endcase
    return r;
  endfunction

  // Stall while an aligned access is being issued or is outstanding; reset forces it low
  assign mem_stall = !rst & (((state_q == IDLE) & access & !misaligned) | (state_q == ACCESS));

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    supp_d        = supp_q;
    bus_err_d     = bus_err_q;
    wb_regwrite_d = 1'b0;
    wb_rdes_d     = 5'd0;
    wb_data_d     = 32'd0;
    wb_valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (misaligned) begin
          bus_err_d  = 1'b1;
          wb_rdes_d  = mem_rdes;
          wb_data_d  = sel_wb(mem_datatoreg, 32'd0, mem_aluout, mem_pcfour, mem_luidata);
          wb_valid_d = 1'b1;
        end else if (access) begin
          req_d   = 1'b1;
          we_d    = mem_memwrite;
          addr_d  = mem_aluout;
          wdata_d = mem_rdatab;
          cnt_d   = 8'd0;
          supp_d  = 1'b0;
          state_d = ACCESS;
        end else begin
          wb_regwrite_d = mem_regwrite;
          wb_rdes_d     = mem_rdes;
          wb_data_d     = sel_wb(mem_datatoreg, 32'd0, mem_aluout, mem_pcfour, mem_luidata);
          wb_valid_d    = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          rdata_d = dmem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
          supp_d    = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        wb_regwrite_d = mem_regwrite & !supp_q;
        wb_rdes_d     = mem_rdes;
        wb_data_d     = sel_wb(mem_datatoreg, rdata_q, mem_aluout, mem_pcfour, mem_luidata);
        wb_valid_d    = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      rdata_q       <= 32'd0;
      supp_q        <= 1'b0;
      bus_err_q     <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rdes_q     <= 5'd0;
      wb_data_q     <= 32'd0;
      wb_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      supp_q        <= supp_d;
      bus_err_q     <= bus_err_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rdes_q     <= wb_rdes_d;
      wb_data_q     <= wb_data_d;
      wb_valid_q    <= wb_valid_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rdes     = wb_rdes_q;
  assign wb_data     = wb_data_q;
  assign wb_valid    = wb_valid_q;
  assign bus_err     = bus_err_q;

endmodule
